// File: rtl/ram_copy_engine.sv
// Block copy / constant fill engine that drives a single-port-write Ram whose
// read data appears one cycle after the read strobe.
module ram_copy_engine #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] srcAddr,
  input  logic [ADDR_WIDTH-1:0] dstAddr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [WIDTH-1:0]      fillValue,
  input  logic                  abort,
  output logic                  ramRe,
  output logic                  ramWe,
  output logic [ADDR_WIDTH-1:0] ramReadAddr,
  output logic [ADDR_WIDTH-1:0] ramWriteAddr,
  output logic [WIDTH-1:0]      ramDataIn,
  input  logic [WIDTH-1:0]      ramDataOut,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  wordsDone
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    FILL,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [WIDTH-1:0]      fill_value_q, fill_value_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic                  aborted_q, aborted_d;
  // Last driven address/data, so the Ram pins hold steady between accesses.
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                  last_word;

  assign last_word = (words_q + LEN_WIDTH'(1)) == len_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    fill_value_d = fill_value_q;
    words_d      = words_q;
    aborted_d    = aborted_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    ramRe        = 1'b0;
    ramWe        = 1'b0;
    ramReadAddr  = rd_addr_q;
    ramWriteAddr = wr_addr_q;
    ramDataIn    = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = srcAddr;
          dst_d        = dstAddr;
          len_d        = len;
          fill_value_d = fillValue;
          words_d      = '0;
          aborted_d    = 1'b0;
          if (len == '0)  state_d = DONE;
          else if (fill)  state_d = FILL;
          else            state_d = READ;
        end
      end
      READ: begin
        ramRe       = 1'b1;
        ramReadAddr = src_q;
        rd_addr_d   = src_q;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d   = WRITE;
        end
      end
      WRITE: begin
        // A word whose read was issued is always written, abort or not.
        ramWe        = 1'b1;
        ramWriteAddr = dst_q;
        ramDataIn    = ramDataOut;
        wr_addr_d    = dst_q;
        wr_data_d    = ramDataOut;
        src_d        = src_q + ADDR_WIDTH'(1);
        dst_d        = dst_q + ADDR_WIDTH'(1);
        words_d      = words_q + LEN_WIDTH'(1);
        if (last_word || abort) begin
          aborted_d = abort;
          state_d   = DONE;
        end else begin
          state_d   = READ;
        end
      end
      FILL: begin
        ramWe        = 1'b1;
        ramWriteAddr = dst_q;
        ramDataIn    = fill_value_q;
        wr_addr_d    = dst_q;
        wr_data_d    = fill_value_q;
        dst_d        = dst_q + ADDR_WIDTH'(1);
        words_d      = words_q + LEN_WIDTH'(1);
        if (last_word || abort) begin
          aborted_d = abort;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      fill_value_q <= '0;
      words_q      <= '0;
      aborted_q    <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      fill_value_q <= fill_value_d;
      words_q      <= words_d;
      aborted_q    <= aborted_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;
  assign wordsDone = words_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: behavioural Ram, array-level reference model and
// a done-driven scoreboard checking word count, abort flag and latency.
module tb_ram_copy_engine;
  localparam int WIDTH = 32;
  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             start = 1'b0;
  logic             fill = 1'b0;
  logic [AW-1:0]    srcAddr = '0;
  logic [AW-1:0]    dstAddr = '0;
  logic [LW-1:0]    len = '0;
  logic [WIDTH-1:0] fillValue = '0;
  logic             abort = 1'b0;
  logic             ramRe, ramWe, busy, done, aborted;
  logic [AW-1:0]    ramReadAddr, ramWriteAddr;
  logic [WIDTH-1:0] ramDataIn;
  logic [WIDTH-1:0] ram_dout = '0;
  logic [LW-1:0]    wordsDone;

  ram_copy_engine #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .res(res), .start(start), .fill(fill),
    .srcAddr(srcAddr), .dstAddr(dstAddr), .len(len), .fillValue(fillValue),
    .abort(abort), .ramRe(ramRe), .ramWe(ramWe),
    .ramReadAddr(ramReadAddr), .ramWriteAddr(ramWriteAddr),
    .ramDataIn(ramDataIn), .ramDataOut(ram_dout),
    .busy(busy), .done(done), .aborted(aborted), .wordsDone(wordsDone)
  );

  always #5 clk = ~clk;

  // Behavioural Ram: write wins over read, read data one cycle after re.
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  typedef struct { int addr; longint t; } wr_t;
  wr_t wr_log[$];
  int  both_cnt = 0;
  int  re_cnt   = 0;

  always @(posedge clk) begin
    if (ramRe && ramWe) both_cnt <= both_cnt + 1;
    if (ramWe) begin
      mem[ramWriteAddr] = ramDataIn;
      wr_log.push_back('{int'(ramWriteAddr), longint'($time)});
    end else if (ramRe) begin
      ram_dout <= mem[ramReadAddr];
      re_cnt   <= re_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: expectations pushed at start, popped when done pulses.
  typedef struct { int words; bit ab; int lat; } exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   start_cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (res && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done at cycle %0d with no transfer pending", cyc);
        end else begin
          e = exp_q.pop_front();
          check("wordsDone", wordsDone, e.words);
          check("aborted", aborted, e.ab);
          check("latency", cyc - start_cyc + 1, e.lat);
        end
      end
    end
  end

  // Reference model: ascending word-by-word copy or fill with address wrap.
  task automatic model(input bit f, input int s, input int d, input int n, input logic [WIDTH-1:0] v);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] sa, da;
      sa = AW'(s + i);
      da = AW'(d + i);
      ref_mem[da] = f ? v : ref_mem[sa];
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // amode: 0 none, 1 abort in READ of word aword, 2 abort in WRITE/FILL of word aword.
  task automatic run_xfer(input string name, input bit f, input int s, input int d, input int l,
                          input logic [WIDTH-1:0] v, input int amode, input int aword,
                          input bit spurious);
    exp_t e;
    bit   got = 0;
    if (amode == 1)      e = '{aword, 1'b1, 2 * aword + 2};
    else if (amode == 2) e = '{aword + 1, 1'b1, f ? aword + 2 : 2 * aword + 3};
    else                 e = '{l, 1'b0, (l == 0) ? 1 : (f ? l + 1 : 2 * l + 1)};
    exp_q.push_back(e);
    model(f, s, d, e.words, v);
    fill = f; srcAddr = AW'(s); dstAddr = AW'(d); len = LW'(l); fillValue = v;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4 * l + 20; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      if ((amode == 1 && ramRe && wordsDone == LW'(aword)) ||
          (amode == 2 && ramWe && wordsDone == LW'(aword))) abort = 1'b1;
      if (spurious && i == 3) begin
        start = 1'b1; fill = ~f; len = LW'(1);
        dstAddr = AW'(d + 7); srcAddr = AW'(s + 9); fillValue = $urandom;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
    end
    check({name, "_done_seen"}, got, 1);
    if (spurious) begin
      start = 1'b1; fill = 1'b1; len = LW'(1); fillValue = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_idle_after"}, busy, 0);
    check_mem({name, "_mem"});
  endtask

  task automatic reset_test();
    bit hit = 0;
    fill = 1'b0; srcAddr = AW'(12'h100); dstAddr = AW'(12'h200); len = LW'(8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ramRe && wordsDone == LW'(3)) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reset_reach_word3", hit, 1);
    model(0, 'h100, 'h200, 3, '0);
    res = 1'b0;
    #1;
    check("reset_ctrl", {ramRe, ramWe, busy, done, aborted}, 0);
    check("reset_addr", {ramReadAddr, ramWriteAddr}, 0);
    check("reset_data", ramDataIn, 0);
    check("reset_words", wordsDone, 0);
    repeat (2) @(posedge clk);
    #2 res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", busy, 0);
    check_mem("reset_mem");
  endtask

  initial begin
    int re0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    #2 res = 1'b0;
    #10;
    check("init_ctrl", {ramRe, ramWe, busy, done, aborted}, 0);
    check("init_addr", {ramReadAddr, ramWriteAddr}, 0);
    check("init_data_words", {ramDataIn, wordsDone}, 0);
    #4 res = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      mem['h10 + i]     = 32'hA0A0_0000 + i;
      ref_mem['h10 + i] = 32'hA0A0_0000 + i;
    end
    run_xfer("copy4", 0, 'h10, 'h40, 4, '0, 0, 0, 0);

    wr_log.delete();
    run_xfer("fill_wrap", 1, 0, 'h3FE, 4, 32'hDEAD_BEEF, 0, 0, 0);
    check("wrap_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("wrap_a0", wr_log[0].addr, 'h3FE);
      check("wrap_a1", wr_log[1].addr, 'h3FF);
      check("wrap_a2", wr_log[2].addr, 'h000);
      check("wrap_a3", wr_log[3].addr, 'h001);
      check("wrap_consecutive", wr_log[3].t - wr_log[0].t, 30);
    end

    wr_log.delete();
    re0 = re_cnt;
    run_xfer("len0", 0, 'h55, 'h66, 0, '0, 0, 0, 0);
    check("len0_writes", wr_log.size(), 0);
    check("len0_reads", re_cnt - re0, 0);

    run_xfer("busy_start", 0, 'h80, 'h90, 5, '0, 0, 0, 1);
    run_xfer("abort_write", 0, 'h150, 'h180, 6, '0, 2, 2, 0);
    run_xfer("abort_read", 0, 'h1A0, 'h1C0, 5, '0, 1, 1, 0);
    run_xfer("abort_fill", 1, 0, 'h2A0, 10, 32'h1234_5678, 2, 2, 0);

    mem['h20] = 32'hCAFE_F00D; ref_mem['h20] = 32'hCAFE_F00D;
    run_xfer("overlap", 0, 'h20, 'h21, 3, '0, 0, 0, 0);
    check("overlap_last", mem['h23], 32'hCAFE_F00D);

    reset_test();
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      run_xfer("rand", 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
               $urandom_range(0, DEPTH - 1), $urandom_range(0, 12), $urandom, 0, 0, 0);
    end

    check("re_we_exclusive", both_cnt, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Initiator-side block-copy/fill engine for the team's single-port-write, latched-read-address `Ram`.
- Drives the Ram's `re`, `we`, `readAddr`, `writeAddr` and `dataIn` and consumes its `dataOut`.
- Copies `len` words from `srcAddr` to `dstAddr` within one Ram, or fills `len` words at `dstAddr` with a constant.
- Sits between a control/CPU register interface and a data Ram; the controller starts it with a one-cycle `start` pulse.

Parameters:
WIDTH, 32, data word width; must equal the attached Ram's WIDTH
ADDR_WIDTH, 10, address width; must equal the attached Ram's ADDR_WIDTH
LEN_WIDTH, 11, width of transfer length and word counter

Ports:
clk  input  1  clock, rising edge
res  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  one-cycle request pulse; sampled only in IDLE
fill  input  1  sampled with start: 1 = fill mode, 0 = copy mode
srcAddr  input  ADDR_WIDTH  copy source base; sampled with start
dstAddr  input  ADDR_WIDTH  destination base; sampled with start
len  input  LEN_WIDTH  number of words; sampled with start
fillValue  input  WIDTH  fill word; sampled with start
abort  input  1  stop request; level, sampled every cycle while busy
ramRe  output  1  to Ram re
ramWe  output  1  to Ram we
ramReadAddr  output  ADDR_WIDTH  to Ram readAddr
ramWriteAddr  output  ADDR_WIDTH  to Ram writeAddr
ramDataIn  output  WIDTH  to Ram dataIn
ramDataOut  input  WIDTH  from Ram dataOut
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
aborted  output  1  valid with done: 1 if the transfer ended by abort
wordsDone  output  LEN_WIDTH  words written in the current/last transfer

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE.
  - All outputs 0: ramRe, ramWe, both ram addresses, ramDataIn, busy, done, aborted, wordsDone.
  - Internal address/length registers cleared.
  - Reset mid-transfer abandons the transfer immediately; no further Ram access occurs.
- Ram contract:
  - `we` has priority over `re` in the Ram, and read data appears on `dataOut` in the cycle after `re`.
  - The engine never asserts ramRe and ramWe in the same cycle.
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE:
  - start=1 latches fill, srcAddr, dstAddr, len and fillValue, and clears wordsDone and aborted.
  - len=0: go to DONE with no Ram access.
  - Otherwise go to READ (fill=0) or FILL (fill=1).
  - start is ignored when busy=1.
- READ (copy):
  - ramRe=1, ramReadAddr=current src.
  - abort=1: go to DONE with aborted=1 and no write for this word.
  - Else go to WRITE.
- WRITE (copy):
  - ramWe=1, ramWriteAddr=current dst, ramDataIn=ramDataOut (combinational pass-through).
  - Increment src, dst and wordsDone.
  - If wordsDone+1==len or abort=1: go to DONE (aborted=abort). Else go to READ.
  - A word whose read has been issued is always written, even if abort is asserted during WRITE.
- FILL:
  - ramWe=1, ramWriteAddr=current dst, ramDataIn=fillValue; one word per cycle.
  - Increment dst and wordsDone.
  - Terminate as in WRITE: on last word or abort, go to DONE (the current word is still written).
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next state is IDLE; a start in this cycle is ignored.
- Throughput and latency:
  - Copy: 2 cycles per word.
  - Fill: 1 cycle per word.
  - Copy latency from start to done = 2*len+1 cycles (start edge to done high).
- Address arithmetic:
  - src and dst increment modulo 2^ADDR_WIDTH, so addresses wrap from max to 0 silently.
  - len counts modulo 2^LEN_WIDTH.
- Overlap: copy is strictly ascending, word by word.
  - dst<src overlap copies correctly.
  - dst>src overlap propagates already-copied data; this is the defined behaviour, not an error.
- Idle outputs: ramRe and ramWe are 0 whenever not in READ/WRITE/FILL. Addresses and data hold their last values.
- wordsDone holds its final value until the next accepted start.

Test Plan:
- Reset: drive res=0 mid-transfer at word 3 of len=8 -> all outputs 0 immediately; after release, Ram words 3..7 of the destination are unchanged.
- Copy: Ram[0x10..0x13]=A,B,C,D; start srcAddr=0x10, dstAddr=0x40, len=4 -> Ram[0x40..0x43]=A,B,C,D; no cycle with ramRe&ramWe; done high 9 cycles after start; wordsDone=4, aborted=0.
- Fill with wrap: ADDR_WIDTH=10, dstAddr=0x3FE, len=4, fillValue=0xDEADBEEF -> addresses 0x3FE, 0x3FF, 0x000, 0x001 written on 4 consecutive cycles; done the following cycle.
- Zero length and ignored start: start with len=0 -> done 1 cycle later, no ramRe/ramWe; start pulsed while busy -> parameters unchanged, transfer unaffected.
- Abort:
  - Abort during WRITE of word 2 (len=6) -> word 2 written, done with aborted=1, wordsDone=3.
  - Abort during READ -> that word is not written.
- Overlapping copy: src=0x20, dst=0x21, len=3, Ram[0x20]=X -> Ram[0x21..0x23]=X,X,X.
